// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. Operands are
//   converted to magnitudes at accept, UNROLL bits are retired per RUN cycle
//   (shift-add for multiply, restoring shift-subtract for divide) and signs
//   are re-applied when the result is registered on entry to DONE.
//
// Parameters
//   WIDTH   operand/result width (even, >= 8)
//   UNROLL  bits retired per RUN cycle (1, 2 or 4; must divide WIDTH)
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   execute-stage instruction is an M op (held while stalled)
//   op         RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b       rs1 / rs2 after forwarding
//   kill       flush of the execute stage this cycle
//   busy       stall request (combinational)
//   out_valid  res is valid for the instruction in execute (one cycle)
//   res        result, held until the next completed op
//
// Configuration
//   MULDIV_EARLY_OUT_EN  when defined, trivial ops (divide by zero, signed
//                        overflow, multiply by zero, |a| < |b| divide) go
//                        straight from IDLE to DONE.
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             kill,
   output logic             busy,
   output logic             out_valid,
   output logic [WIDTH-1:0] res
);

   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   logic [1:0]         state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   mb_q, mb_d;      // multiplicand / divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;    // {hi, lo} product or {rem, quo}
   logic               sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_q, res_d;

   logic               accept, load_res;
   logic               sa_in, sb_in, dz_in;
   logic [WIDTH-1:0]   ma_in, mb_in;
   logic [WIDTH-1:0]   quo, rem;
   logic [2*WIDTH-1:0] prod;

   assign accept = (state_q == S_IDLE) & in_valid & ~kill;
   assign busy   = ~rst & (accept | (state_q == S_RUN));
   // Kill in DONE retires nothing, so the pulse is masked combinationally.
   assign out_valid = (state_q == S_DONE) & ~kill;
   assign res       = res_q;

   // Operand decode at accept.
   assign sa_in = (op == OP_MUL || op == OP_MULH || op == OP_MULHSU ||
                   op == OP_DIV || op == OP_REM) & a[WIDTH-1];
   assign sb_in = (op == OP_MUL || op == OP_MULH ||
                   op == OP_DIV || op == OP_REM) & b[WIDTH-1];
   assign ma_in = sa_in ? -a : a;
   assign mb_in = sb_in ? -b : b;
   assign dz_in = op[2] & (b == '0);

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   logic               mul_zero, div_ovf, div_small, early;
   logic [2*WIDTH-1:0] early_acc;

   assign mul_zero  = ~op[2] & ((a == '0) | (b == '0));
   assign div_ovf   = ((op == OP_DIV) | (op == OP_REM)) & (a == MOST_NEG) & (b == '1);
   assign div_small = op[2] & (ma_in < mb_in);
   assign early     = mul_zero | dz_in | div_ovf | div_small;

   // Accumulator images that the normal sign/select stage turns into the
   // architectural result without any iterations.
   always_comb begin
      if (mul_zero)       early_acc = '0;
      else if (dz_in)     early_acc = {ma_in, {WIDTH{1'b1}}};
      else if (div_small) early_acc = {ma_in, {WIDTH{1'b0}}};
      else                early_acc = {{WIDTH{1'b0}}, ma_in};
   end
`endif

   // UNROLL iterations of shift-add (multiply) or restoring division.
   function automatic logic [2*WIDTH-1:0] iterate(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   d,
                                                  input logic               is_div);
      logic [WIDTH-1:0] hi, lo;
      logic [WIDTH:0]   t;
      hi = acc[2*WIDTH-1:WIDTH];
      lo = acc[WIDTH-1:0];
      for (int i = 0; i < UNROLL; i++) begin
         if (is_div) begin
            t  = {hi, lo[WIDTH-1]};
            lo = {lo[WIDTH-2:0], 1'b0};
            if (t >= {1'b0, d}) begin
               t     = t - {1'b0, d};
               lo[0] = 1'b1;
            end
            hi = t[WIDTH-1:0];
         end else begin
            t  = lo[0] ? ({1'b0, hi} + {1'b0, d}) : {1'b0, hi};
            lo = {t[0], lo[WIDTH-1:1]};
            hi = t[WIDTH:1];
         end
      end
      return {hi, lo};
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mb_d     = mb_q;
      acc_d    = acc_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      dz_d     = dz_q;
      cnt_d    = cnt_q;
      load_res = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = op;
               sa_d    = sa_in;
               sb_d    = sb_in;
               dz_d    = dz_in;
               mb_d    = mb_in;
               acc_d   = {{WIDTH{1'b0}}, ma_in};
               cnt_d   = '0;
               state_d = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
               if (early) begin
                  acc_d    = early_acc;
                  state_d  = S_DONE;
                  load_res = 1'b1;
               end
`endif
            end
         end
         S_RUN: begin
            acc_d = iterate(acc_q, mb_q, op_q[2]);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               load_res = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (kill) begin
         state_d  = S_IDLE;
         load_res = 1'b0;
      end
   end

   // Sign application and result select, from the values being registered.
   always_comb begin
      prod = (sa_d ^ sb_d) ? -acc_d : acc_d;
      quo  = dz_d ? {WIDTH{1'b1}}
                  : ((sa_d ^ sb_d) ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0]);
      rem  = sa_d ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
      res_d = res_q;
      if (load_res) begin
         case (op_d)
            OP_MUL:                       res_d = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              res_d = quo;
            OP_REM, OP_REMU:              res_d = rem;
            default:                      res_d = res_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         mb_q    <= '0;
         acc_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
//   Two instances (UNROLL=1 and UNROLL=4, WIDTH=32) driven with directed and
//   random RV32M ops; results come from a plain-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_v [2];
   logic [2:0]  op_v       [2];
   logic [31:0] a_v        [2];
   logic [31:0] b_v        [2];
   logic        kill_v     [2];
   logic        busy_v     [2];
   logic        out_valid_v[2];
   logic [31:0] res_v      [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.WIDTH(32), .UNROLL(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .op(op_v[0]),
      .a(a_v[0]), .b(b_v[0]), .kill(kill_v[0]), .busy(busy_v[0]),
      .out_valid(out_valid_v[0]), .res(res_v[0]));

   ex_muldiv_unit #(.WIDTH(32), .UNROLL(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .op(op_v[1]),
      .a(a_v[1]), .b(b_v[1]), .kill(kill_v[1]), .busy(busy_v[1]),
      .out_valid(out_valid_v[1]), .res(res_v[1]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
      longint          sx, sy;
      longint unsigned ux, uy;
      logic [63:0]     p;
      logic            ovf;
      sx  = longint'(signed'(x));
      sy  = longint'(signed'(y));
      ux  = {32'd0, x};
      uy  = {32'd0, y};
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (o)
         3'd0: begin p = ux * uy; return p[31:0]; end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * longint'(uy); return p[63:32]; end
         3'd3: begin p = ux * uy; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (ovf)    return x;
            p = sx / sy; return p[31:0];
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (ovf)    return 32'd0;
            p = sx % sy; return p[31:0];
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   // Number of cycles busy stays high for an op.
   function automatic int exp_stall(input logic [2:0] o, input logic [31:0] x,
                                    input logic [31:0] y, input int n);
      bit     sgn, early;
      longint mx, my;
      sgn = (o == 3'd4) || (o == 3'd6);
      mx  = sgn ? longint'(signed'(x)) : longint'({32'd0, x});
      my  = sgn ? longint'(signed'(y)) : longint'({32'd0, y});
      if (mx < 0) mx = -mx;
      if (my < 0) my = -my;
      if (o < 3'd4) early = (x == 0) || (y == 0);
      else          early = (y == 0) || (mx < my) ||
                            (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
      return (EARLY_EN && early) ? 1 : n + 1;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         4:       return -32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input int u, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input string tag);
      int          stall, n;
      logic [31:0] e;
      n = (u == 0) ? 32 : 8;
      e = ref_model(o, x, y);
      @(negedge clk);
      in_valid_v[u] = 1'b1;
      op_v[u]       = o;
      a_v[u]        = x;
      b_v[u]        = y;
      #1;
      stall = 0;
      while (busy_v[u] && stall < 100) begin
         stall++;
         @(negedge clk);
         #1;
      end
      check({tag, " stall"}, 64'(stall), 64'(exp_stall(o, x, y, n)));
      check({tag, " out_valid"}, 64'(out_valid_v[u]), 64'd1);
      check({tag, " res"}, 64'(res_v[u]), 64'(e));
      @(negedge clk);
      in_valid_v[u] = 1'b0;
      #1;
      check({tag, " pulse"}, 64'(out_valid_v[u]), 64'd0);
      check({tag, " hold"}, 64'(res_v[u]), 64'(e));
   endtask

   initial begin
      logic [31:0] held;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         in_valid_v[u] = 1'b0; op_v[u] = '0; a_v[u] = '0; b_v[u] = '0; kill_v[u] = 1'b0;
      end
      #2;
      for (int u = 0; u < 2; u++) begin
         check("reset busy", 64'(busy_v[u]), 64'd0);
         check("reset out_valid", 64'(out_valid_v[u]), 64'd0);
         check("reset res", 64'(res_v[u]), 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Directed cases.
      run_op(0, 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, "mulh -1*2");
      run_op(0, 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, "mul -1*2");
      run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
      run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");
      run_op(0, 3'd5, 32'd7, 32'd0, "divu by0");
      run_op(0, 3'd7, 32'd7, 32'd0, "remu by0");
      run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd0, "div neg by0");
      run_op(0, 3'd0, 32'd5, 32'd0, "mul 5*0");
      run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu -1*max");
      run_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, "u4 div -7/2");
      run_op(1, 3'd6, 32'hFFFF_FFF9, 32'd2, "u4 rem -7/2");
      run_op(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "u4 mulhu max");

      // Random ops on both instances.
      for (int i = 0; i < 40; i++) begin
         run_op(i % 2, 3'($urandom_range(0, 7)), rand_operand(), rand_operand(), "random");
      end

      // Kill during RUN cycle 5: abort, no pulse, result unchanged.
      held = res_v[0];
      @(negedge clk);
      in_valid_v[0] = 1'b1; op_v[0] = 3'd5; a_v[0] = 32'd100; b_v[0] = 32'd7;
      repeat (5) @(negedge clk);
      kill_v[0] = 1'b1;
      #1;
      check("kill busy in run", 64'(busy_v[0]), 64'd1);
      check("kill out_valid", 64'(out_valid_v[0]), 64'd0);
      @(negedge clk);
      kill_v[0] = 1'b0; in_valid_v[0] = 1'b0;
      #1;
      check("after kill busy", 64'(busy_v[0]), 64'd0);
      check("after kill out_valid", 64'(out_valid_v[0]), 64'd0);
      check("after kill res", 64'(res_v[0]), 64'(held));
      run_op(0, 3'd5, 32'd100, 32'd7, "divu 100/7 reaccept");

      // Kill together with in_valid in IDLE suppresses the accept.
      @(negedge clk);
      in_valid_v[1] = 1'b1; op_v[1] = 3'd0; a_v[1] = 32'd3; b_v[1] = 32'd3; kill_v[1] = 1'b1;
      #1;
      check("kill accept busy", 64'(busy_v[1]), 64'd0);
      @(negedge clk);
      kill_v[1] = 1'b0; in_valid_v[1] = 1'b0;
      #1;
      check("kill accept idle busy", 64'(busy_v[1]), 64'd0);
      check("kill accept out_valid", 64'(out_valid_v[1]), 64'd0);

      // Asynchronous reset between edges in the middle of RUN.
      @(negedge clk);
      in_valid_v[0] = 1'b1; op_v[0] = 3'd3; a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'hFFFF_FFFF;
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async rst busy", 64'(busy_v[0]), 64'd0);
      check("async rst out_valid", 64'(out_valid_v[0]), 64'd0);
      check("async rst res", 64'(res_v[0]), 64'd0);
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("post rst idle busy", 64'(busy_v[0]), 64'd0);
      check("post rst res", 64'(res_v[0]), 64'd0);
      run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, "mulh min*min");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
